// File: rtl/alu_seq_if.sv
// Operand-issue / result handshake bundle for alu_seq.
// The issuing side drives the operands and the result-side ready (master);
// the ALU drives in_ready plus the registered result and flags (slave).
interface alu_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_A;
    logic [WIDTH-1:0] in_B;
    logic             c_in;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             c_out;
    logic             f_zero;
    logic             f_negative;
    logic             f_overflow;
    logic             f_parity;

    modport master (
        output in_valid, in_A, in_B, c_in, op, out_ready,
        input  in_ready, out_valid, out, c_out,
               f_zero, f_negative, f_overflow, f_parity
    );

    modport slave (
        input  in_valid, in_A, in_B, c_in, op, out_ready,
        output in_ready, out_valid, out, c_out,
               f_zero, f_negative, f_overflow, f_parity
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential handshaked ALU: 16 opcodes, single-cycle arithmetic/logic,
// shifts and rotates walk one bit per clock, result and flags are held in
// a registered valid/ready output stage until the consumer takes them.
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam logic [3:0] OP_PASS = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADDC = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_SUBC = 4'h4;
    localparam logic [3:0] OP_NEG  = 4'h5;
    localparam logic [3:0] OP_INC  = 4'h6;
    localparam logic [3:0] OP_DEC  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOT  = 4'hB;

    localparam logic [WIDTH:0]     ONE_X   = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]   MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   work_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [1:0]         shop_q;
    logic [WIDTH-1:0]   out_q;
    logic               cout_q;
    logic               zero_q;
    logic               neg_q;
    logic               ovf_q;
    logic               par_q;
    logic               valid_q;

    logic               accept;
    logic               startShift;
    logic [SHAMT_W-1:0] amt;
    logic               isArith;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   res_d;
    logic               cout_d;
    logic               ovf_d;
    logic [WIDTH-1:0]   step_d;
    logic               stepBit_d;

    // Ready in IDLE, or in DONE when the held result is being taken this cycle.
    assign bus.in_ready = rst_n && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;
    assign amt          = bus.in_B[SHAMT_W-1:0];
    assign startShift   = (bus.op[3:2] == 2'b11) && (amt != '0);

    // Single-cycle result for every op; shifts only use it when the amount is 0 (out=A, c_out=0).
    always_comb begin
        sum     = '0;
        isArith = 1'b0;
        res_d   = bus.in_A;
        cout_d  = 1'b0;
        ovf_d   = 1'b0;
        case (bus.op)
            OP_PASS: res_d = bus.in_A;
            OP_ADD, OP_ADDC: begin
                isArith = 1'b1;
                sum     = {1'b0, bus.in_A} + {1'b0, bus.in_B}
                        + ((bus.op == OP_ADDC) ? {{WIDTH{1'b0}}, bus.c_in} : '0);
                ovf_d   = (bus.in_A[WIDTH-1] == bus.in_B[WIDTH-1])
                       && (sum[WIDTH-1] != bus.in_A[WIDTH-1]);
            end
            OP_SUB, OP_SUBC: begin
                isArith = 1'b1;
                sum     = {1'b0, bus.in_A} + {1'b0, ~bus.in_B}
                        + ((bus.op == OP_SUBC) ? {{WIDTH{1'b0}}, bus.c_in} : ONE_X);
                ovf_d   = (bus.in_A[WIDTH-1] != bus.in_B[WIDTH-1])
                       && (sum[WIDTH-1] != bus.in_A[WIDTH-1]);
            end
            OP_NEG: begin
                isArith = 1'b1;
                sum     = {1'b0, ~bus.in_A} + ONE_X;
                ovf_d   = (bus.in_A == MIN_NEG);
            end
            OP_INC: begin
                isArith = 1'b1;
                sum     = {1'b0, bus.in_A} + ONE_X;
                ovf_d   = (bus.in_A == MAX_POS);
            end
            OP_DEC: begin
                isArith = 1'b1;
                sum     = {1'b0, bus.in_A} + {1'b0, {WIDTH{1'b1}}};
                ovf_d   = (bus.in_A == MIN_NEG);
            end
            OP_AND:  res_d = bus.in_A & bus.in_B;
            OP_OR:   res_d = bus.in_A | bus.in_B;
            OP_XOR:  res_d = bus.in_A ^ bus.in_B;
            OP_NOT:  res_d = ~bus.in_A;
            default: res_d = bus.in_A;
        endcase
        if (isArith) begin
            res_d  = sum[WIDTH-1:0];
            cout_d = sum[WIDTH];
        end
    end

    // One-bit step of the in-flight shift/rotate and the bit that leaves the word.
    always_comb begin
        step_d    = work_q;
        stepBit_d = 1'b0;
        case (shop_q)
            2'b00: begin
                stepBit_d = work_q[0];
                step_d    = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            end
            2'b01: begin
                stepBit_d = work_q[0];
                step_d    = {1'b0, work_q[WIDTH-1:1]};
            end
            2'b10: begin
                stepBit_d = work_q[WIDTH-1];
                step_d    = {work_q[WIDTH-2:0], 1'b0};
            end
            default: begin
                stepBit_d = work_q[WIDTH-1];
                step_d    = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            end
        endcase
    end

    // Control FSM with registered result, flags and out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            shop_q  <= '0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (accept) begin
            if (startShift) begin
                work_q  <= bus.in_A;
                cnt_q   <= amt;
                shop_q  <= bus.op[1:0];
                valid_q <= 1'b0;
                state_q <= SHIFT;
            end else begin
                out_q   <= res_d;
                cout_q  <= cout_d;
                ovf_q   <= ovf_d;
                zero_q  <= (res_d == '0);
                neg_q   <= res_d[WIDTH-1];
                par_q   <= ^res_d;
                valid_q <= 1'b1;
                state_q <= DONE;
            end
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q == CNT_ONE) begin
                        out_q   <= step_d;
                        cout_q  <= stepBit_d;
                        ovf_q   <= 1'b0;
                        zero_q  <= (step_d == '0);
                        neg_q   <= step_d[WIDTH-1];
                        par_q   <= ^step_d;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        work_q <= step_d;
                        cnt_q  <= cnt_q - CNT_ONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out        = out_q;
    assign bus.c_out      = cout_q;
    assign bus.f_zero     = zero_q;
    assign bus.f_negative = neg_q;
    assign bus.f_overflow = ovf_q;
    assign bus.f_parity   = par_q;
endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed cases plus a randomised run, checked
// through a scoreboard of expected results fed by an independent model.
module tb_alu_seq;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [7:0] out;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
        logic       p;
    } exp_t;

    logic clk;
    logic rst_n;
    int   testCount = 0;
    int   failCount = 0;
    int   lastLow   = 0;
    logic randomReady = 1'b0;
    exp_t sb[$];

    alu_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it when the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
        end
    endtask

    // Reference ALU written from the arithmetic meaning of each opcode.
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
        exp_t       e;
        int         sa;
        int         sbv;
        int         r;
        int         amt;
        logic [7:0] w;
        e   = '0;
        sa  = $signed(a);
        sbv = $signed(b);
        w   = a;
        amt = int'(b[2:0]);
        case (op)
            4'h1: begin r = sa + sbv; w = 8'(int'(a) + int'(b));
                  e.c = (int'(a) + int'(b)) > 255; e.v = (r > 127) || (r < -128); end
            4'h2: begin r = sa + sbv + int'(cin); w = 8'(int'(a) + int'(b) + int'(cin));
                  e.c = (int'(a) + int'(b) + int'(cin)) > 255; e.v = (r > 127) || (r < -128); end
            4'h3: begin r = sa - sbv; w = 8'(int'(a) - int'(b));
                  e.c = int'(a) >= int'(b); e.v = (r > 127) || (r < -128); end
            4'h4: begin r = sa - sbv - 1 + int'(cin); w = 8'(int'(a) - int'(b) - 1 + int'(cin));
                  e.c = (int'(a) + int'(cin)) > int'(b); e.v = (r > 127) || (r < -128); end
            4'h5: begin r = -sa; w = 8'(0 - int'(a)); e.c = (a == 8'h00); e.v = (r > 127); end
            4'h6: begin r = sa + 1; w = 8'(int'(a) + 1); e.c = (a == 8'hFF); e.v = (r > 127); end
            4'h7: begin r = sa - 1; w = 8'(int'(a) - 1); e.c = (a != 8'h00); e.v = (r < -128); end
            4'h8: w = a & b;
            4'h9: w = a | b;
            4'hA: w = a ^ b;
            4'hB: w = ~a;
            4'hC: if (amt != 0) begin w = 8'($signed(a) >>> amt); e.c = a[amt-1]; end
            4'hD: if (amt != 0) begin w = a >> amt; e.c = a[amt-1]; end
            4'hE: if (amt != 0) begin w = a << amt; e.c = a[8-amt]; end
            4'hF: if (amt != 0) begin w = (a << amt) | (a >> (8 - amt)); e.c = w[0]; end
            default: w = a;
        endcase
        e.out = w;
        e.z   = (w == 8'h00);
        e.n   = w[7];
        e.p   = ^w;
        return e;
    endfunction

    // Presents one op and holds it until accepted; the expected result is queued
    // at the accepting edge. Returns at #1 after that edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, output int waited);
        logic done;
        waited       = 0;
        done         = 1'b0;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.in_A     = a;
        bus.in_B     = b;
        bus.c_in     = cin;
        if (randomReady) bus.out_ready = 1'($urandom_range(0, 1));
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(model(op, a, b, cin));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                waited++;
                if (waited > 50) begin
                    checkOutput("acceptTimeout", 32'(bus.in_ready), 1);
                    done = 1'b1;
                end
                if (randomReady) bus.out_ready = 1'($urandom_range(0, 1));
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // Directed op: checks immediate accept, latency to out_valid and the result value.
    task automatic runOne(input string name, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input int expLat, input logic [7:0] expOut);
        int waited;
        int lat;
        int lowCycles;
        applyStimulus(op, a, b, cin, waited);
        checkOutput({name, "_acceptWait"}, waited, 0);
        lat       = 1;
        lowCycles = 0;
        while (!bus.out_valid && lat < 30) begin
            if (!bus.in_ready) lowCycles++;
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({name, "_latency"}, lat, expLat);
        checkOutput({name, "_out"}, 32'(bus.out), 32'(expOut));
        lastLow = lowCycles;
    endtask

    // Scoreboard: every handshaken result is compared with the oldest queued expectation.
    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("sbUnderflow", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                checkOutput("sb_out",      32'(bus.out),        32'(e.out));
                checkOutput("sb_cout",     32'(bus.c_out),      32'(e.c));
                checkOutput("sb_zero",     32'(bus.f_zero),     32'(e.z));
                checkOutput("sb_negative", 32'(bus.f_negative), 32'(e.n));
                checkOutput("sb_overflow", 32'(bus.f_overflow), 32'(e.v));
                checkOutput("sb_parity",   32'(bus.f_parity),   32'(e.p));
            end
        end
    end

    // Main sequence: reset, spec cases, backpressure, streaming, mid-shift reset, random run.
    initial begin
        int waited;
        int validCycles;

        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_A      = '0;
        bus.in_B      = '0;
        bus.c_in      = 1'b0;
        bus.op        = '0;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_inReady",  32'(bus.in_ready), 0);
        checkOutput("rst_outValid", 32'(bus.out_valid), 0);
        checkOutput("rst_outs", {bus.out, bus.c_out, bus.f_zero, bus.f_negative, bus.f_overflow, bus.f_parity}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_inReady", 32'(bus.in_ready), 1);

        runOne("add7F", 4'h1, 8'h7F, 8'h01, 1'b0, 1, 8'h80);
        checkOutput("add7F_flags", {bus.c_out, bus.f_zero, bus.f_negative, bus.f_overflow, bus.f_parity}, 5'b00111);
        runOne("sub05", 4'h3, 8'h05, 8'h05, 1'b0, 1, 8'h00);
        checkOutput("sub05_flags", {bus.c_out, bus.f_zero, bus.f_negative, bus.f_overflow, bus.f_parity}, 5'b11000);
        runOne("inc7F", 4'h6, 8'h7F, 8'h00, 1'b0, 1, 8'h80);
        checkOutput("inc7F_overflow", 32'(bus.f_overflow), 1);
        runOne("rol81", 4'hF, 8'h81, 8'h03, 1'b0, 4, 8'h0C);
        checkOutput("rol81_readyLow", lastLow, 3);
        checkOutput("rol81_cout", 32'(bus.c_out), 0);
        runOne("asr80", 4'hC, 8'h80, 8'h02, 1'b0, 3, 8'hE0);
        checkOutput("asr80_cout", 32'(bus.c_out), 0);
        runOne("lsrA5", 4'hD, 8'hA5, 8'h00, 1'b0, 1, 8'hA5);
        checkOutput("lsrA5_cout", 32'(bus.c_out), 0);

        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        runOne("bpAdd", 4'h1, 8'h7F, 8'h01, 1'b0, 1, 8'h80);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp_hold%0d", i),
                        {bus.out_valid, bus.in_ready, bus.out, bus.c_out,
                         bus.f_zero, bus.f_negative, bus.f_overflow, bus.f_parity},
                        {1'b1, 1'b0, 8'h80, 1'b0, 4'b0111});
        end
        bus.out_ready = 1'b1;
        applyStimulus(4'h1, 8'h01, 8'h01, 1'b0, waited);
        checkOutput("bp_sameCycle", waited, 0);
        checkOutput("bp_nextOut", {bus.out_valid, bus.out}, {1'b1, 8'h02});

        validCycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0 && bus.out_valid) validCycles++;
            applyStimulus(4'h1, 8'(i + 1), 8'h10, 1'b0, waited);
            checkOutput($sformatf("stream_accept%0d", i), waited, 0);
        end
        if (bus.out_valid) validCycles++;
        checkOutput("stream_validCycles", validCycles, 10);

        applyStimulus(4'hD, 8'hFF, 8'h07, 1'b0, waited);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRst_outs",
                    {bus.in_ready, bus.out_valid, bus.out, bus.c_out,
                     bus.f_zero, bus.f_negative, bus.f_overflow, bus.f_parity}, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postRst_inReady", 32'(bus.in_ready), 1);
        validCycles = 0;
        repeat (10) begin
            if (bus.out_valid) validCycles++;
            @(posedge clk);
            #1;
        end
        checkOutput("postRst_noStale", validCycles, 0);

        randomReady = 1'b1;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(4'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), waited);
        end
        randomReady   = 1'b0;
        bus.out_ready = 1'b1;
        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("sbDrained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
